// File: rtl/convolver_window_controller.sv
// Sliding-window convolver controller: accepts a frame of pixels, strobes the
// line-buffer shift, tracks (row, col) and flags when a full K x K window is held.
// Optional build macro WINDOW_CTRL_STRIDE2_EN restricts window_valid to stride-2 positions.
module convolver_window_controller #(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned COL_WIDTH   = 10,
  parameter int unsigned ROW_WIDTH   = 10
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [COL_WIDTH-1:0] img_width,
  input  logic [ROW_WIDTH-1:0] img_height,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 shift_en,
  output logic [COL_WIDTH-1:0] col,
  output logic [ROW_WIDTH-1:0] row,
  output logic                 window_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned KM1 = KERNEL_SIZE - 1;
`ifdef WINDOW_CTRL_STRIDE2_EN
  localparam logic KM1_ODD = 1'(KM1 % 2);
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 err_d;
  logic [COL_WIDTH-1:0] col_last_q;
  logic [ROW_WIDTH-1:0] row_last_q;
  logic                 start_acc_c;
  logic                 dims_legal_c;
  logic                 last_col_c;
  logic                 last_pixel_c;
  logic                 win_hit_c;

  // Handshake is purely combinational so a stall never shifts the window.
  assign in_ready     = (state_q == ST_STREAM);
  assign shift_en     = in_valid && in_ready;
  assign start_acc_c  = (state_q == ST_IDLE) && start;
  assign dims_legal_c = (32'(img_width) >= KERNEL_SIZE) && (32'(img_height) >= KERNEL_SIZE);
  assign last_col_c   = (col == col_last_q);
  assign last_pixel_c = shift_en && last_col_c && (row == row_last_q);

`ifdef WINDOW_CTRL_STRIDE2_EN
  assign win_hit_c = (32'(row) >= KM1) && (32'(col) >= KM1) &&
                     (row[0] == KM1_ODD) && (col[0] == KM1_ODD);
`else
  assign win_hit_c = (32'(row) >= KM1) && (32'(col) >= KM1);
`endif

  // Next-state logic; err_d marks a DONE entered from an illegal start.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dims_legal_c) begin
            state_d = ST_STREAM;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (last_pixel_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == ST_STREAM);
      done    <= (state_d == ST_DONE);
      error   <= (state_d == ST_DONE) && err_d;
    end
  end

  // Frame bounds are latched as last-index values so wrap detection is a plain compare.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col          <= '0;
      row          <= '0;
      col_last_q   <= '0;
      row_last_q   <= '0;
      window_valid <= 1'b0;
    end else begin
      window_valid <= shift_en && win_hit_c;
      if (start_acc_c) begin
        col        <= '0;
        row        <= '0;
        col_last_q <= img_width - COL_WIDTH'(1);
        row_last_q <= img_height - ROW_WIDTH'(1);
      end else if (shift_en) begin
        if (last_col_c) begin
          col <= '0;
          row <= row + ROW_WIDTH'(1);
        end else begin
          col <= col + COL_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_convolver_window_controller.sv
// Directed bench for convolver_window_controller (K=3, 10-bit counters).
module tb_convolver_window_controller;

  localparam int K  = 3;
  localparam int CW = 10;
  localparam int RW = 10;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] img_width = '0;
  logic [RW-1:0] img_height = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          shift_en;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          window_valid;
  logic          busy;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;

  convolver_window_controller #(
    .KERNEL_SIZE(K),
    .COL_WIDTH  (CW),
    .ROW_WIDTH  (RW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .img_width   (img_width),
    .img_height  (img_height),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .shift_en    (shift_en),
    .col         (col),
    .row         (row),
    .window_valid(window_valid),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  function automatic logic win_expected(input int r, input int c);
    logic hit;
    hit = (r >= K - 1) && (c >= K - 1);
`ifdef WINDOW_CTRL_STRIDE2_EN
    hit = hit && (((r - (K - 1)) % 2) == 0) && (((c - (K - 1)) % 2) == 0);
`endif
    return hit;
  endfunction

  task automatic do_start(input int w, input int h);
    @(negedge clock);
    start      = 1'b1;
    img_width  = CW'(w);
    img_height = RW'(h);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Streams pixels from the current negedge, tallying observations against a bench model.
  task automatic stream_frame(input int w, input int h, input int mode, input int stop_hs,
                              input int start_at, output int nhs, output int n_shift,
                              output int n_bad_shift, output int wv_cnt, output int wv_bad,
                              output int pos_bad, output int rdy_bad, output int got_done,
                              output int done_lag, output int err_at_done);
    int   total;
    int   br;
    int   bc;
    int   last_cyc;
    logic exp_wv;
    total = w * h;
    br = 0; bc = 0; last_cyc = -1;
    nhs = 0; n_shift = 0; n_bad_shift = 0; wv_cnt = 0; wv_bad = 0;
    pos_bad = 0; rdy_bad = 0; got_done = 0; done_lag = -1; err_at_done = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (cyc == start_at) begin
        start      = 1'b1;
        img_width  = CW'(3);
        img_height = RW'(3);
      end else begin
        start = 1'b0;
      end
      #1;
      if (nhs < total && in_ready !== 1'b1) rdy_bad++;
      if (shift_en !== (in_valid & in_ready)) n_bad_shift++;
      exp_wv = 1'b0;
      if (shift_en === 1'b1) begin
        n_shift++;
        if (col !== CW'(bc) || row !== RW'(br)) pos_bad++;
        exp_wv = win_expected(br, bc);
        nhs++;
        last_cyc = cyc;
        if (bc == w - 1) begin
          bc = 0;
          br++;
        end else begin
          bc++;
        end
      end
      @(negedge clock);
      if (window_valid !== exp_wv) wv_bad++;
      if (window_valid === 1'b1) wv_cnt++;
      if (done === 1'b1) begin
        got_done    = 1;
        done_lag    = cyc - last_cyc;
        err_at_done = int'(error);
        break;
      end
      if (stop_hs != 0 && nhs == stop_hs) break;
    end
    start = 1'b0;
  endtask

`ifdef WINDOW_CTRL_STRIDE2_EN
  localparam int EXP_WIN_5X4 = 2;
  localparam int EXP_WIN_7X7 = 9;
`else
  localparam int EXP_WIN_5X4 = 6;
  localparam int EXP_WIN_7X7 = 25;
`endif

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({in_ready, shift_en, window_valid, busy, done, error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {in_ready, shift_en, window_valid, busy, done, error});
    end
    checks++;
    if (col !== '0 || row !== '0) begin
      errors++;
      $display("FAIL reset_counters: got col %0d row %0d want 0 0", col, row);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got ready %b done %b want 0 0", in_ready, done);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    int nhs, nsh, nbs, wvc, wvb, pb, rb, gd, dl, ed;
    do_start(5, 4);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL full_busy: got %b want 1", busy);
    end
    stream_frame(5, 4, 0, 0, -1, nhs, nsh, nbs, wvc, wvb, pb, rb, gd, dl, ed);
    checks++;
    if (nhs !== 20) begin errors++; $display("FAIL full_handshakes: got %0d want 20", nhs); end
    checks++;
    if (wvc !== EXP_WIN_5X4) begin
      errors++; $display("FAIL full_windows: got %0d want %0d", wvc, EXP_WIN_5X4);
    end
    checks++;
    if (wvb !== 0) begin errors++; $display("FAIL full_window_align: got %0d bad want 0", wvb); end
    checks++;
    if (pb !== 0 || rb !== 0 || nbs !== 0) begin
      errors++; $display("FAIL full_position: got pos %0d rdy %0d shift %0d want 0", pb, rb, nbs);
    end
    checks++;
    if (gd !== 1 || dl !== 0 || ed !== 0) begin
      errors++; $display("FAIL full_done: got done %0d lag %0d err %0d want 1 0 0", gd, dl, ed);
    end
    @(negedge clock);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_back_idle: got done %b busy %b ready %b want 0", done, busy, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    int nhs, nsh, nbs, wvc, wvb, pb, rb, gd, dl, ed;
    do_start(5, 4);
    stream_frame(5, 4, 1, 0, -1, nhs, nsh, nbs, wvc, wvb, pb, rb, gd, dl, ed);
    checks++;
    if (nsh !== 20 || nbs !== 0) begin
      errors++; $display("FAIL stall_shifts: got %0d bad %0d want 20 0", nsh, nbs);
    end
    checks++;
    if (wvc !== EXP_WIN_5X4 || wvb !== 0) begin
      errors++; $display("FAIL stall_windows: got %0d bad %0d want %0d 0", wvc, wvb, EXP_WIN_5X4);
    end
    checks++;
    if (gd !== 1 || dl !== 0 || pb !== 0) begin
      errors++; $display("FAIL stall_done: got done %0d lag %0d pos %0d want 1 0 0", gd, dl, pb);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic test_illegal();
    int ws[3] = '{2, 0, 1};
    int hs[3] = '{4, 5, 1};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      do_start(ws[i], hs[i]);
      #1;
      checks++;
      if (done !== 1'b1 || error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal_%0dx%0d: got done %b err %b ready %b busy %b want 1 1 0 0",
                 ws[i], hs[i], done, error, in_ready, busy);
      end
      @(negedge clock);
      #1;
      checks++;
      if (done !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL illegal_idle_%0d: got done %b err %b ready %b want 0 0 0",
                 i, done, error, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_min_frame();
    int nhs, nsh, nbs, wvc, wvb, pb, rb, gd, dl, ed;
    do_start(3, 3);
    stream_frame(3, 3, 0, 0, -1, nhs, nsh, nbs, wvc, wvb, pb, rb, gd, dl, ed);
    checks++;
    if (nhs !== 9 || wvc !== 1 || wvb !== 0) begin
      errors++; $display("FAIL min_frame: got hs %0d win %0d bad %0d want 9 1 0", nhs, wvc, wvb);
    end
    checks++;
    if (gd !== 1 || ed !== 0) begin
      errors++; $display("FAIL min_done: got done %0d err %0d want 1 0", gd, ed);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int nhs, nsh, nbs, wvc, wvb, pb, rb, gd, dl, ed;
    int done_seen;
    do_start(5, 4);
    stream_frame(5, 4, 0, 7, -1, nhs, nsh, nbs, wvc, wvb, pb, rb, gd, dl, ed);
    checks++;
    if (nhs !== 7 || gd !== 0) begin
      errors++; $display("FAIL abort_setup: got hs %0d done %0d want 7 0", nhs, gd);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, shift_en, window_valid, busy, done, error} !== 6'b0 ||
        col !== '0 || row !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got flags %b col %0d row %0d want 0",
               {in_ready, shift_en, window_valid, busy, done, error}, col, row);
    end
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (done === 1'b1) done_seen++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (done === 1'b1 || in_ready === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++; $display("FAIL abort_no_done: got %0d events want 0", done_seen);
    end
    do_start(5, 4);
    stream_frame(5, 4, 0, 0, -1, nhs, nsh, nbs, wvc, wvb, pb, rb, gd, dl, ed);
    checks++;
    if (nhs !== 20 || wvc !== EXP_WIN_5X4 || wvb !== 0 || pb !== 0 || gd !== 1) begin
      errors++;
      $display("FAIL abort_refill: got hs %0d win %0d bad %0d pos %0d done %0d want 20 %0d 0 0 1",
               nhs, wvc, wvb, pb, gd, EXP_WIN_5X4);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic test_start_ignored();
    int nhs, nsh, nbs, wvc, wvb, pb, rb, gd, dl, ed;
    do_start(5, 4);
    stream_frame(5, 4, 0, 0, 4, nhs, nsh, nbs, wvc, wvb, pb, rb, gd, dl, ed);
    checks++;
    if (nhs !== 20 || wvc !== EXP_WIN_5X4 || pb !== 0 || gd !== 1) begin
      errors++;
      $display("FAIL start_ignored: got hs %0d win %0d pos %0d done %0d want 20 %0d 0 1",
               nhs, wvc, pb, gd, EXP_WIN_5X4);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic test_big_frame();
    int nhs, nsh, nbs, wvc, wvb, pb, rb, gd, dl, ed;
    do_start(7, 7);
    stream_frame(7, 7, 1, 0, -1, nhs, nsh, nbs, wvc, wvb, pb, rb, gd, dl, ed);
    checks++;
    if (nsh !== 49 || nbs !== 0) begin
      errors++; $display("FAIL big_shifts: got %0d bad %0d want 49 0", nsh, nbs);
    end
    checks++;
    if (wvc !== EXP_WIN_7X7 || wvb !== 0 || gd !== 1) begin
      errors++;
      $display("FAIL big_windows: got %0d bad %0d done %0d want %0d 0 1", wvc, wvb, gd, EXP_WIN_7X7);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_illegal();
    test_min_frame();
    test_reset_midframe();
    test_start_ignored();
    test_big_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
